exec_issue_ctrl: RTL and testbench

- Issue-side controller for the integer/FPU execute unit: accepts one decoded operation from the decode stage and drives the unit's request bus (op class, function code, operands).
- Holds the request stable for exactly the unit's fixed latency, then drops to NOP and captures the registered result.
- Presents the result to writeback as a one-cycle valid pulse.
- Initiator end of the execute unit's fixed-latency, no-handshake protocol; stalls decode while an operation is in flight.

---
 rtl/exec_pkg.sv | 60 ++++++
 rtl/exec_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_exec_issue_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the issue controller and the execute unit.
package exec_pkg;

    // Op class on the unit request bus
    localparam logic [1:0] CLS_IMM     = 2'b00;
    localparam logic [1:0] CLS_SPECIAL = 2'b01;
    localparam logic [1:0] CLS_FPU     = 2'b10;

    // Special / R-type funct codes
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Immediate opcodes
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    // FPU funct codes
    localparam logic [5:0] FPU_ADD  = 6'b000000;
    localparam logic [5:0] FPU_SUB  = 6'b000001;
    localparam logic [5:0] FPU_MUL  = 6'b000010;
    localparam logic [5:0] FPU_INV  = 6'b000011;
    localparam logic [5:0] FPU_SQRT = 6'b000100;
    localparam logic [5:0] FPU_ABS  = 6'b000101;
    localparam logic [5:0] FPU_FTOI = 6'b001000;
    localparam logic [5:0] FPU_ITOF = 6'b001001;
    localparam logic [5:0] FPU_EQ   = 6'b110010;
    localparam logic [5:0] FPU_LT   = 6'b110100;
    localparam logic [5:0] FPU_LE   = 6'b110110;

    // Matches no unit case, so the unit's result register holds
    localparam logic [5:0] NOP_CODE = 6'b111110;

    typedef struct packed {
        logic [1:0]  cls;
        logic [5:0]  code;
        logic [31:0] s;
        logic [31:0] t;
        logic [31:0] imm;
        logic [4:0]  h;
        logic [4:0]  rd;
    } exec_req_t;

    function automatic logic fpu_is_long(input logic [5:0] code);
        return (code == FPU_ADD) || (code == FPU_SUB) ||
               (code == FPU_MUL) || (code == FPU_SQRT);
    endfunction

    function automatic logic fpu_is_supported(input logic [5:0] code);
        return fpu_is_long(code) || (code == FPU_INV) ||
               (code == FPU_EQ) || (code == FPU_LT) || (code == FPU_LE) ||
               (code == FPU_FTOI) || (code == FPU_ITOF);
    endfunction

endpackage

// File: rtl/exec_issue_ctrl.sv
// Issue-side controller for the fixed-latency integer/FPU execute unit.
module exec_issue_ctrl
    import exec_pkg::*;
#(
    parameter int unsigned SHORT_LAT    = 1,
    parameter int unsigned FPU_LONG_LAT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_class,
    input  logic [5:0]  in_code,
    input  logic [31:0] in_s,
    input  logic [31:0] in_t,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_h,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic [1:0]  eu_class,
    output logic [5:0]  eu_code,
    output logic [31:0] eu_s,
    output logic [31:0] eu_t,
    output logic [31:0] eu_imm,
    output logic [4:0]  eu_h,
    input  logic [31:0] eu_d,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2
    } state_t;

    state_t    state, state_n;
    exec_req_t req;
    logic [1:0] lat;
    logic [1:0] cnt;
    logic       is_long;
    logic       flush_pend;
    logic       accept;
    logic       in_long;

    assign accept  = (state == S_IDLE) && in_valid && !flush;
    assign in_long = (in_class == CLS_FPU) && fpu_is_long(in_code);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next state and unit request bus; the bus is NOP outside EXEC
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        eu_class = CLS_IMM;
        eu_code  = NOP_CODE;
        eu_s     = '0;
        eu_t     = '0;
        eu_imm   = '0;
        eu_h     = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) state_n = S_EXEC;
            end
            S_EXEC: begin
                eu_class = req.cls;
                eu_code  = req.code;
                eu_s     = req.s;
                eu_t     = req.t;
                eu_imm   = req.imm;
                eu_h     = req.h;
                // A long FPU op must run out so the unit's counter wraps to 0
                if (flush && !is_long) state_n = S_IDLE;
                else if (cnt == lat)   state_n = S_CAPT;
            end
            S_CAPT: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Request latch, latency counter, flush tracking and writeback capture
    always_ff @(posedge clk) begin
        if (!rstn) begin
            req        <= '0;
            lat        <= '0;
            cnt        <= '0;
            is_long    <= 1'b0;
            flush_pend <= 1'b0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rd      <= '0;
            wb_err     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req        <= '{cls: in_class, code: in_code, s: in_s, t: in_t,
                                        imm: in_imm, h: in_h, rd: in_rd};
                        lat        <= in_long ? 2'(FPU_LONG_LAT) : 2'(SHORT_LAT);
                        is_long    <= in_long;
                        cnt        <= 2'd1;
                        flush_pend <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (cnt != lat) cnt <= cnt + 2'd1;
                    if (flush && is_long) flush_pend <= 1'b1;
                end
                S_CAPT: begin
                    if (!flush && !flush_pend) begin
                        wb_valid <= 1'b1;
                        wb_data  <= eu_d;
                        wb_rd    <= req.rd;
                        wb_err   <= (req.cls == CLS_FPU) && !fpu_is_supported(req.code);
                    end
                    flush_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Directed plus randomized bench for exec_issue_ctrl with a behavioural execute unit.
module tb_exec_issue_ctrl;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, flush;
    logic [1:0]  in_class, eu_class;
    logic [5:0]  in_code, eu_code;
    logic [31:0] in_s, in_t, in_imm, eu_s, eu_t, eu_imm, eu_d, wb_data;
    logic [4:0]  in_h, in_rd, eu_h, wb_rd;
    logic        wb_valid, wb_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] ref_d;

    exec_issue_ctrl #(.SHORT_LAT(1), .FPU_LONG_LAT(3)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_code(in_code), .in_s(in_s), .in_t(in_t),
        .in_imm(in_imm), .in_h(in_h), .in_rd(in_rd), .flush(flush),
        .eu_class(eu_class), .eu_code(eu_code), .eu_s(eu_s), .eu_t(eu_t),
        .eu_imm(eu_imm), .eu_h(eu_h), .eu_d(eu_d), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // float32 <-> real for the unit model (normal numbers and zero only)
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:0] == 31'd0) return 0.0;
        b = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return 32'd0;
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Reference conversion of a small positive integer to float32
    function automatic logic [31:0] i2f(input int unsigned n);
        int unsigned p;
        logic [31:0] m;
        p = 0;
        if (n == 0) return 32'd0;
        for (int i = 0; i < 32; i++) if (n[i]) p = i;
        m = n << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Behavioural execute unit: short ops write on the next edge, long FPU ops on the third
    logic [1:0]  u_fcnt;
    logic [31:0] u_d;
    assign eu_d = u_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            u_d    <= 32'd0;
            u_fcnt <= 2'd0;
        end else begin
            case (eu_class)
                CLS_SPECIAL: case (eu_code)
                    FN_ADD: u_d <= eu_s + eu_t;
                    FN_SUB: u_d <= eu_s - eu_t;
                    FN_SLL: u_d <= eu_t << eu_h;
                    default: ;
                endcase
                CLS_IMM: case (eu_code)
                    OP_ADDI: u_d <= eu_s + eu_imm;
                    OP_SLTI: u_d <= {31'd0, $signed(eu_s) < $signed(eu_imm)};
                    default: ;
                endcase
                CLS_FPU: if (eu_code == FPU_ADD || eu_code == FPU_SUB ||
                             eu_code == FPU_MUL || eu_code == FPU_SQRT) begin
                    if (u_fcnt == 2'd2) begin
                        u_fcnt <= 2'd0;
                        case (eu_code)
                            FPU_ADD: u_d <= r2f(f2r(eu_s) + f2r(eu_t));
                            FPU_SUB: u_d <= r2f(f2r(eu_s) - f2r(eu_t));
                            FPU_MUL: u_d <= r2f(f2r(eu_s) * f2r(eu_t));
                            default: u_d <= r2f($sqrt(f2r(eu_s)));
                        endcase
                    end else begin
                        u_fcnt <= u_fcnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [5:0] code, input logic [31:0] s,
                         input logic [31:0] t, input logic [31:0] imm, input logic [4:0] h,
                         input logic [4:0] rd);
        in_valid = 1'b1; in_class = c; in_code = code;
        in_s = s; in_t = t; in_imm = imm; in_h = h; in_rd = rd;
    endtask

    // Issue one op and check bus hold, stall and the writeback pulse at lat+2 cycles
    task automatic do_op(input string tag, input logic [1:0] c, input logic [5:0] code,
                         input logic [31:0] s, input logic [31:0] t, input logic [31:0] imm,
                         input logic [4:0] h, input logic [4:0] rd,
                         input logic [31:0] exp_d, input logic exp_err);
        int unsigned lat;
        lat = (c == 2'b10 && (code == 6'd0 || code == 6'd1 || code == 6'd2 || code == 6'd4)) ? 3 : 1;
        chk({tag, ":ready_pre"}, in_ready, 1);
        drive(c, code, s, t, imm, h, rd);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= int'(lat) + 1; k++) begin
            chk({tag, ":stall"}, in_ready, 0);
            chk({tag, ":wb_early"}, wb_valid, 0);
            if (k <= int'(lat)) begin
                chk({tag, ":bus_code"}, eu_code, code);
                chk({tag, ":bus_class"}, eu_class, c);
                chk({tag, ":bus_s"}, eu_s, s);
            end else begin
                chk({tag, ":nop_code"}, eu_code, NOP_CODE);
                chk({tag, ":nop_class"}, eu_class, 0);
            end
            step();
        end
        chk({tag, ":wb_valid"}, wb_valid, 1);
        chk({tag, ":wb_data"}, wb_data, exp_d);
        chk({tag, ":wb_rd"}, wb_rd, rd);
        chk({tag, ":wb_err"}, wb_err, exp_err);
        chk({tag, ":ready_post"}, in_ready, 1);
    endtask

    initial begin
        logic [31:0] s, t, imm, exp_d;
        logic [4:0]  h, rd;
        int unsigned a, b, kind;

        rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; in_class = '0; in_code = '0;
        in_s = '0; in_t = '0; in_imm = '0; in_h = '0; in_rd = '0;
        repeat (3) step();
        chk("rst:in_ready", in_ready, 1);
        chk("rst:wb_valid", wb_valid, 0);
        chk("rst:wb_data", wb_data, 0);
        chk("rst:wb_rd", wb_rd, 0);
        chk("rst:wb_err", wb_err, 0);
        chk("rst:eu_class", eu_class, 0);
        chk("rst:eu_code", eu_code, NOP_CODE);
        chk("rst:eu_s", eu_s, 0);
        chk("rst:eu_imm", eu_imm, 0);
        rstn = 1'b1;
        step();

        do_op("add", CLS_SPECIAL, FN_ADD, 32'd5, 32'd7, 32'd0, 5'd0, 5'd3, 32'd12, 1'b0);
        do_op("fmul", CLS_FPU, FPU_MUL, 32'h4000_0000, 32'h4040_0000, 32'd0, 5'd0, 5'd9,
              32'h40C0_0000, 1'b0);

        // Back-to-back with in_valid held: second accept on the first wb cycle
        drive(CLS_IMM, OP_ADDI, 32'd1, 32'd0, 32'd2, 5'd0, 5'd4);
        step();
        drive(CLS_IMM, OP_SLTI, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd5);
        step(); step();
        chk("b2b:wb1_valid", wb_valid, 1);
        chk("b2b:wb1_data", wb_data, 3);
        chk("b2b:wb1_rd", wb_rd, 4);
        chk("b2b:ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("b2b:accepted", in_ready, 0);
        chk("b2b:gap1", wb_valid, 0);
        step();
        chk("b2b:gap2", wb_valid, 0);
        step();
        chk("b2b:wb2_valid", wb_valid, 1);
        chk("b2b:wb2_data", wb_data, 1);
        chk("b2b:wb2_rd", wb_rd, 5);

        // Long FPU SUB flushed mid-flight runs out on the bus, no writeback
        drive(CLS_FPU, FPU_SUB, i2f(5), i2f(2), 32'd0, 5'd0, 5'd6);
        step();
        in_valid = 1'b0;
        chk("fsub:c1", eu_code, FPU_SUB);
        step();
        flush = 1'b1;
        chk("fsub:c2", eu_code, FPU_SUB);
        step();
        flush = 1'b0;
        chk("fsub:c3", eu_code, FPU_SUB);
        chk("fsub:no_wb3", wb_valid, 0);
        step();
        chk("fsub:c4_nop", eu_code, NOP_CODE);
        chk("fsub:no_wb4", wb_valid, 0);
        step();
        chk("fsub:no_wb5", wb_valid, 0);
        chk("fsub:ready", in_ready, 1);
        chk("fsub:unit_cnt", u_fcnt, 0);
        chk("fsub:unit_d", u_d, i2f(3));
        do_op("add_after", CLS_SPECIAL, FN_ADD, 32'd100, 32'd23, 32'd0, 5'd0, 5'd7, 32'd123, 1'b0);
        ref_d = 32'd123;

        // Unsupported FPU code: short latency, error flag, result register untouched
        do_op("fabs", CLS_FPU, FPU_ABS, i2f(4), 32'd0, 32'd0, 5'd0, 5'd8, ref_d, 1'b1);
        chk("fabs:unit_d", u_d, ref_d);
        step();
        chk("fabs:pulse_end", wb_valid, 0);
        chk("fabs:err_end", wb_err, 0);

        // Flush in IDLE blocks acceptance
        drive(CLS_SPECIAL, FN_ADD, 32'd1, 32'd1, 32'd0, 5'd0, 5'd1);
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("fidle:ready", in_ready, 1);
        chk("fidle:nop", eu_code, NOP_CODE);
        step(); step();
        chk("fidle:no_wb", wb_valid, 0);

        // Flush during short EXEC returns to IDLE at once
        drive(CLS_SPECIAL, FN_ADD, 32'd2, 32'd3, 32'd0, 5'd0, 5'd2);
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fexec:ready", in_ready, 1);
        chk("fexec:nop", eu_code, NOP_CODE);
        step();
        chk("fexec:no_wb", wb_valid, 0);

        // Flush during CAPT suppresses the pulse
        drive(CLS_SPECIAL, FN_ADD, 32'd4, 32'd4, 32'd0, 5'd0, 5'd2);
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fcapt:no_wb", wb_valid, 0);
        chk("fcapt:ready", in_ready, 1);
        chk("fcapt:unit_d", u_d, 32'd8);

        // Reset in the middle of a long FPU op
        drive(CLS_FPU, FPU_ADD, i2f(1), i2f(2), 32'd0, 5'd0, 5'd3);
        step();
        in_valid = 1'b0;
        step();
        rstn = 1'b0;
        step();
        chk("rstmid:ready", in_ready, 1);
        chk("rstmid:class", eu_class, 0);
        chk("rstmid:code", eu_code, NOP_CODE);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rstmid:no_wb", wb_valid, 0);
            step();
        end
        chk("rstmid:unit_d", u_d, 0);
        ref_d = 32'd0;

        // Randomized ops against arithmetic expectations
        for (int n = 0; n < 40; n++) begin
            s = $urandom; t = $urandom; imm = $urandom;
            h = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
            a = $urandom_range(1, 100); b = $urandom_range(1, 100);
            kind = $urandom_range(0, 8);
            case (kind)
                0: begin exp_d = s + t; do_op("r_add", CLS_SPECIAL, FN_ADD, s, t, imm, h, rd, exp_d, 1'b0); end
                1: begin exp_d = s - t; do_op("r_sub", CLS_SPECIAL, FN_SUB, s, t, imm, h, rd, exp_d, 1'b0); end
                2: begin exp_d = t << h; do_op("r_sll", CLS_SPECIAL, FN_SLL, s, t, imm, h, rd, exp_d, 1'b0); end
                3: begin exp_d = s + imm; do_op("r_addi", CLS_IMM, OP_ADDI, s, t, imm, h, rd, exp_d, 1'b0); end
                4: begin
                    exp_d = (int'(s) < int'(imm)) ? 32'd1 : 32'd0;
                    do_op("r_slti", CLS_IMM, OP_SLTI, s, t, imm, h, rd, exp_d, 1'b0);
                end
                5: begin exp_d = i2f(a + b); do_op("r_fadd", CLS_FPU, FPU_ADD, i2f(a), i2f(b), imm, h, rd, exp_d, 1'b0); end
                6: begin exp_d = i2f(a * b); do_op("r_fmul", CLS_FPU, FPU_MUL, i2f(a), i2f(b), imm, h, rd, exp_d, 1'b0); end
                7: begin exp_d = i2f(a); do_op("r_fsqrt", CLS_FPU, FPU_SQRT, i2f(a * a), t, imm, h, rd, exp_d, 1'b0); end
                default: begin exp_d = ref_d; do_op("r_fabs", CLS_FPU, FPU_ABS, s, t, imm, h, rd, exp_d, 1'b1); end
            endcase
            ref_d = exp_d;
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                step();
                chk("r_gap:no_wb", wb_valid, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
